// File: rtl/dac_stream_pkg.sv
// Shared constants and helpers for the DAC stream scaler: default widths,
// lane count, unity gain, sample limits and lane slicing.
package dac_stream_pkg;

  localparam int DEF_AXIS_DATA_WIDTH = 256;
  localparam int DEF_DAC_DATA_WIDTH  = 16;
  localparam int DEF_GAIN_WIDTH      = 18;
  localparam int DEF_GAIN_FRAC_BITS  = 16;

  localparam int LANES      = DEF_AXIS_DATA_WIDTH / DEF_DAC_DATA_WIDTH;
  localparam int UNITY_GAIN = 32'sd1 << DEF_GAIN_FRAC_BITS;
  localparam int SAMPLE_MAX = (32'sd1 << (DEF_DAC_DATA_WIDTH - 1)) - 32'sd1;
  localparam int SAMPLE_MIN = -(32'sd1 << (DEF_DAC_DATA_WIDTH - 1));

  // Bit offset of a lane within a beat; lane 0 sits in the least significant bits.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dac_lane_scaler.sv
// One lane of the scaler: S1 multiply, S2 round/shift/offset, S3 saturate.
// All stages advance together on ce and hold otherwise.
module dac_lane_scaler #(
  parameter int DW   = 16,
  parameter int GW   = 18,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          byp_i,
  input  logic [GW-1:0] gain_i,
  input  logic [DW-1:0] off_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          sat_o
);

  localparam int PW = DW + GW;
  localparam int RW = PW - FRAC;
  localparam int YW = RW + 2;
  localparam logic signed [PW-1:0] HALF  = PW'(1'b1) << (FRAC - 1);
  localparam logic signed [YW-1:0] Y_MAX = YW'({(DW - 1){1'b1}});
  localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;

  logic signed [PW-1:0] din_ext, gain_ext, p1_d, p1_q, rnd;
  logic signed [RW-1:0] r2;
  logic signed [YW-1:0] y2_d, y2_q;
  logic [DW-1:0]        q3_d, q3_q;
  logic                 sat3_d, sat3_q;

  // Bypass feeds the sample at unity scale so rounding returns it unchanged.
  always_comb begin
    din_ext  = PW'($signed(din_i));
    gain_ext = PW'($signed(gain_i));
    if (byp_i) begin
      p1_d = din_ext <<< FRAC;
    end else begin
      p1_d = din_ext * gain_ext;
    end
    rnd  = p1_q + HALF;
    r2   = RW'(rnd >>> FRAC);
    y2_d = YW'(r2) + YW'($signed(off_i));
    if (y2_q > Y_MAX) begin
      q3_d   = Y_MAX[DW-1:0];
      sat3_d = 1'b1;
    end else if (y2_q < Y_MIN) begin
      q3_d   = Y_MIN[DW-1:0];
      sat3_d = 1'b1;
    end else begin
      q3_d   = y2_q[DW-1:0];
      sat3_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q   <= {PW{1'b0}};
      y2_q   <= {YW{1'b0}};
      q3_q   <= {DW{1'b0}};
      sat3_q <= 1'b0;
    end else if (ce) begin
      p1_q   <= p1_d;
      y2_q   <= y2_d;
      q3_q   <= q3_d;
      sat3_q <= sat3_d;
    end
  end

  assign dout_o = q3_q;
  assign sat_o  = sat3_q;

endmodule

// File: rtl/dac_stream_scaler.sv
// AXI-Stream gain/offset/round/saturate stage for packed signed DAC samples.
// Define DAC_STREAM_SCALER_SAT_COUNT_EN to add the satCount beat counter output.
module dac_stream_scaler
  import dac_stream_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
  parameter int DAC_DATA_WIDTH  = DEF_DAC_DATA_WIDTH,
  parameter int GAIN_WIDTH      = DEF_GAIN_WIDTH,
  parameter int GAIN_FRAC_BITS  = DEF_GAIN_FRAC_BITS
) (
  input  logic                       axis_CLK,
  input  logic                       axis_RESET,
  input  logic [GAIN_WIDTH-1:0]      cfgGain,
  input  logic [DAC_DATA_WIDTH-1:0]  cfgOffset,
  input  logic                       cfgBypass,
  input  logic                       cfgStrobe,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_TDATA,
  input  logic                       s_axis_TVALID,
  output logic                       s_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_TDATA,
  output logic                       m_axis_TVALID,
  input  logic                       m_axis_TREADY,
  output logic                       satFlag
`ifdef DAC_STREAM_SCALER_SAT_COUNT_EN
  ,
  output logic [31:0]                satCount
`endif
);

  localparam int N_LANES = AXIS_DATA_WIDTH / DAC_DATA_WIDTH;
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(1'b1) << GAIN_FRAC_BITS;

  logic [GAIN_WIDTH-1:0]     sh_gain_q, sh_gain_d, act_gain_q, act_gain_d, eff_gain;
  logic [DAC_DATA_WIDTH-1:0] sh_off_q, sh_off_d, act_off_q, act_off_d, eff_off;
  logic [DAC_DATA_WIDTH-1:0] off1_q, off1_d;
  logic                      sh_byp_q, sh_byp_d, act_byp_q, act_byp_d, eff_byp;
  logic                      pend_q, pend_d;
  logic                      v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                      sat_q, sat_d;
  logic                      ce, out_sat_hs;
  logic [N_LANES-1:0]        lane_sat;

  assign ce            = !v3_q || m_axis_TREADY;
  assign s_axis_TREADY = ce;
  assign m_axis_TVALID = v3_q;
  assign satFlag       = sat_q;
  assign out_sat_hs    = v3_q && m_axis_TREADY && (|lane_sat);

  // A pending strobe makes the shadow set the one the next accepted beat sees.
  always_comb begin
    eff_gain = pend_q ? sh_gain_q : act_gain_q;
    eff_off  = pend_q ? sh_off_q  : act_off_q;
    eff_byp  = pend_q ? sh_byp_q  : act_byp_q;
    sh_gain_d = sh_gain_q;
    sh_off_d  = sh_off_q;
    sh_byp_d  = sh_byp_q;
    if (cfgStrobe) begin
      sh_gain_d = cfgGain;
      sh_off_d  = cfgOffset;
      sh_byp_d  = cfgBypass;
      pend_d    = 1'b1;
    end else if (ce) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (ce) begin
      act_gain_d = eff_gain;
      act_off_d  = eff_off;
      act_byp_d  = eff_byp;
      off1_d     = eff_byp ? {DAC_DATA_WIDTH{1'b0}} : eff_off;
      v1_d       = s_axis_TVALID;
      v2_d       = v1_q;
      v3_d       = v2_q;
    end else begin
      act_gain_d = act_gain_q;
      act_off_d  = act_off_q;
      act_byp_d  = act_byp_q;
      off1_d     = off1_q;
      v1_d       = v1_q;
      v2_d       = v2_q;
      v3_d       = v3_q;
    end
    if (cfgStrobe) begin
      sat_d = 1'b0;
    end else if (out_sat_hs) begin
      sat_d = 1'b1;
    end else begin
      sat_d = sat_q;
    end
  end

  always_ff @(posedge axis_CLK or posedge axis_RESET) begin
    if (axis_RESET) begin
      sh_gain_q  <= GAIN_ONE;
      sh_off_q   <= {DAC_DATA_WIDTH{1'b0}};
      sh_byp_q   <= 1'b0;
      act_gain_q <= GAIN_ONE;
      act_off_q  <= {DAC_DATA_WIDTH{1'b0}};
      act_byp_q  <= 1'b0;
      pend_q     <= 1'b0;
      off1_q     <= {DAC_DATA_WIDTH{1'b0}};
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      sh_gain_q  <= sh_gain_d;
      sh_off_q   <= sh_off_d;
      sh_byp_q   <= sh_byp_d;
      act_gain_q <= act_gain_d;
      act_off_q  <= act_off_d;
      act_byp_q  <= act_byp_d;
      pend_q     <= pend_d;
      off1_q     <= off1_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      sat_q      <= sat_d;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    dac_lane_scaler #(
      .DW   (DAC_DATA_WIDTH),
      .GW   (GAIN_WIDTH),
      .FRAC (GAIN_FRAC_BITS)
    ) u_lane (
      .clk    (axis_CLK),
      .rst    (axis_RESET),
      .ce     (ce),
      .byp_i  (eff_byp),
      .gain_i (eff_gain),
      .off_i  (off1_q),
      .din_i  (s_axis_TDATA[lane_lo(i, DAC_DATA_WIDTH) +: DAC_DATA_WIDTH]),
      .dout_o (m_axis_TDATA[lane_lo(i, DAC_DATA_WIDTH) +: DAC_DATA_WIDTH]),
      .sat_o  (lane_sat[i])
    );
  end

`ifdef DAC_STREAM_SCALER_SAT_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counts clamped output beats, sticking at all-ones.
  always_comb begin
    if (cfgStrobe) begin
      cnt_d = 32'd0;
    end else if (out_sat_hs && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge axis_CLK or posedge axis_RESET) begin
    if (axis_RESET) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign satCount = cnt_q;
`endif

endmodule
